sram_share_arbiter: RTL and testbench

- Shares the single-port data SRAM between two requesters: master 0 (the load/store path feeding the memory stage) and master 1 (a secondary client such as a refill/debug engine).
- Round-robin arbitration with a same-cycle grant. Exactly one SRAM access is issued per cycle.
- Read data returns one cycle after grant with a per-master valid strobe. A saturating conflict counter supports performance analysis.

---
 rtl/sram_share_arbiter.sv | 119 +++++++++++
 tb/tb_sram_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_share_arbiter.sv
// sram_share_arbiter: shares one single-port data SRAM between master 0
// (load/store path) and master 1 (refill/debug client). Round-robin with a
// same-cycle grant, one SRAM access per cycle, and read data returned one
// cycle after the grant. A saturating counter tracks contention cycles.
//
// Handshake: a master raises req with wr/wstrb/addr/wdata and holds them
// stable until it sees gnt high in the same cycle; that cycle is the transfer.
// Dropping req before gnt withdraws the request. rvalid is a single-cycle
// strobe with no back-pressure; rdata is meaningful only while rvalid is high.
module sram_share_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [3:0]        m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [3:0]        m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // Index of the most recently granted master; the other one wins a tie.
    logic rr_last;
    // A read was granted last cycle and its data is on sram_rdata now.
    logic rd_pending;
    // Which master owns the returning read data.
    logic rd_owner;
    // A read is being issued to the SRAM this cycle.
    logic rd_issue;
    logic any_gnt;
    logic both_req;

    // Round-robin grant: a lone requester always wins; on a tie the master
    // that was not granted last wins.
    always_comb begin
        m0_gnt = m0_req & (~m1_req | rr_last);
        m1_gnt = m1_req & (~m0_req | ~rr_last);
    end

    // Derived per-cycle qualifiers used by the registers below.
    always_comb begin
        any_gnt  = m0_gnt | m1_gnt;
        both_req = m0_req & m1_req;
        rd_issue = (m0_gnt & ~m0_wr) | (m1_gnt & ~m1_wr);
    end

    // SRAM port mux: master 0 drives address/data unless master 1 is granted;
    // byte enables are only raised for a granted write.
    always_comb begin
        sram_en    = any_gnt;
        sram_addr  = m0_addr;
        sram_wdata = m0_wdata;
        sram_wen   = 4'b0000;
        if (m1_gnt) begin
            sram_addr  = m1_addr;
            sram_wdata = m1_wdata;
        end
        if (m0_gnt && m0_wr) begin
            sram_wen = m0_wstrb;
        end else if (m1_gnt && m1_wr) begin
            sram_wen = m1_wstrb;
        end
    end

    // Arbitration history and read-return tracking. Reset wins over a grant
    // made in the reset cycle, so such a read never produces rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last    <= 1'b1;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            if (any_gnt) begin
                rr_last <= m1_gnt;
            end
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_owner <= m1_gnt;
            end
        end
    end

    // Saturating count of cycles in which both masters were requesting.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (both_req && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    // Read return: SRAM data is broadcast, the strobe goes to the owner only.
    always_comb begin
        m0_rvalid = rd_pending & ~rd_owner;
        m1_rvalid = rd_pending & rd_owner;
        m0_rdata  = sram_rdata;
        m1_rdata  = sram_rdata;
    end

endmodule

// File: tb/tb_sram_share_arbiter.sv
// Testbench for sram_share_arbiter: directed vectors with hand-computed
// expectations. Read responses go through an expected queue that a separate
// monitor drains on every rvalid; grants and SRAM drive are checked per cycle.
module tb_sram_share_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic [15:0] conflict_cnt;

    // Second instance with a narrow counter, sharing all inputs.
    logic        s_m0_gnt, s_m0_rvalid, s_m1_gnt, s_m1_rvalid, s_sram_en;
    logic [31:0] s_m0_rdata, s_m1_rdata, s_sram_addr, s_sram_wdata;
    logic [3:0]  s_sram_wen;
    logic [3:0]  s_conflict_cnt;

    int checks   = 0;
    int failures = 0;
    int n_g0     = 0;
    int n_g1     = 0;

    logic [32:0] exp_q[$];

    sram_share_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
    );

    sram_share_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
        .sram_en(s_sram_en), .sram_wen(s_sram_wen), .sram_addr(s_sram_addr),
        .sram_wdata(s_sram_wdata), .sram_rdata(sram_rdata), .conflict_cnt(s_conflict_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- SRAM model ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] cur;

    initial begin
        mem[32'h0000_0010] = 32'hDEAD_BEEF;
        mem[32'h0000_0020] = 32'hCAFE_F00D;
        mem[32'h0000_0100] = 32'hAAAA_AAAA;
        sram_rdata = 32'h0;
    end

    // Single-port synchronous SRAM: byte-masked write, read data next cycle.
    always @(posedge clk) begin
        if (sram_en) begin
            cur = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
            if (sram_wen != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) cur[8*b +: 8] = sram_wdata[8*b +: 8];
                mem[sram_addr] = cur;
            end else begin
                sram_rdata <= cur;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic wr, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m0_req = req; m0_wr = wr; m0_wstrb = strb; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic wr, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
        m1_req = req; m1_wr = wr; m1_wstrb = strb; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // One cycle: check grants and SRAM drive mid-cycle, queue expected read
    // data for granted reads, then advance to just after the next edge.
    task automatic tick(input logic eg0, input logic eg1,
                        input logic [31:0] ed0, input logic [31:0] ed1);
        logic [3:0] ewen;
        @(negedge clk);
        check("m0_gnt", {31'b0, m0_gnt}, {31'b0, eg0});
        check("m1_gnt", {31'b0, m1_gnt}, {31'b0, eg1});
        check("sram_en", {31'b0, sram_en}, {31'b0, eg0 | eg1});
        ewen = 4'b0000;
        if (eg0 && m0_wr) ewen = m0_wstrb;
        else if (eg1 && m1_wr) ewen = m1_wstrb;
        check("sram_wen", {28'b0, sram_wen}, {28'b0, ewen});
        if (eg0) begin
            check("sram_addr", sram_addr, m0_addr);
            if (m0_wr) check("sram_wdata", sram_wdata, m0_wdata);
        end else if (eg1) begin
            check("sram_addr", sram_addr, m1_addr);
            if (m1_wr) check("sram_wdata", sram_wdata, m1_wdata);
        end
        if (m0_gnt === 1'b1) n_g0++;
        if (m1_gnt === 1'b1) n_g1++;
        if (!reset) begin
            if (eg0 && !m0_wr) exp_q.push_back({1'b0, ed0});
            if (eg1 && !m1_wr) exp_q.push_back({1'b1, ed1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_cnt", {16'b0, conflict_cnt}, 32'd0);
        check("reset_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        check("reset_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [32:0] item;
    logic [32:0] got;

    // Pop and compare the oldest expected read on every rvalid strobe.
    always @(negedge clk) begin
        if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
            checks++;
            got = {m1_rvalid, (m1_rvalid ? m1_rdata : m0_rdata)};
            if (m0_rvalid && m1_rvalid) begin
                failures++;
                $display("FAIL rvalid_both: got m0=1 m1=1 required one-hot");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected: got owner=%0d data=%h required none",
                         got[32], got[31:0]);
            end else begin
                item = exp_q.pop_front();
                if (got !== item)
                    begin
                        failures++;
                        $display("FAIL rdata: got owner=%0d data=%h required owner=%0d data=%h",
                                 got[32], got[31:0], item[32], item[31:0]);
                    end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        idle();
        do_reset();

        // Single master read
        set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        tick(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
        idle();
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        check("single_cnt", {16'b0, conflict_cnt}, 32'd0);

        // Tie after reset: master 0 first
        do_reset();
        set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        set_m1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        tick(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
        set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D);
        idle();
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        check("tie_cnt", {16'b0, conflict_cnt}, 32'd1);

        // Sustained contention, back-to-back pipelined reads
        do_reset();
        n_g0 = 0;
        n_g1 = 0;
        set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        set_m1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        for (int i = 0; i < 10; i++)
            tick((i % 2) == 0, (i % 2) == 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        idle();
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        check("contend_cnt", {16'b0, conflict_cnt}, 32'd10);
        check("contend_sat_cnt", {28'b0, s_conflict_cnt}, 32'd10);
        check("contend_g0", n_g0, 32'd5);
        check("contend_g1", n_g1, 32'd5);

        // Byte write by master 1, then read-back by master 0
        set_m1(1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234_5678);
        tick(1'b0, 1'b1, 32'h0, 32'h0);
        idle();
        set_m0(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        tick(1'b1, 1'b0, 32'hAAAA_5678, 32'h0);
        // m0 write vs m1 read tie: master 0 was last, master 1 wins
        set_m0(1'b1, 1'b1, 4'b1111, 32'h104, 32'h5566_7788);
        set_m1(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        tick(1'b0, 1'b1, 32'h0, 32'hAAAA_5678);
        set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b1, 1'b0, 4'h0, 32'h104, 32'h0);
        tick(1'b0, 1'b1, 32'h0, 32'h5566_7788);
        idle();
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        check("mixed_cnt", {16'b0, conflict_cnt}, 32'd11);

        // Saturation of the narrow counter
        do_reset();
        set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        set_m1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick((i % 2) == 0, (i % 2) == 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
            if (i == 14) check("sat_cnt_at15", {28'b0, s_conflict_cnt}, 32'd15);
            if (i == 15) check("sat_cnt_at16", {28'b0, s_conflict_cnt}, 32'd15);
        end
        idle();
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        check("sat_cnt_wide", {16'b0, conflict_cnt}, 32'd20);
        check("sat_cnt_narrow", {28'b0, s_conflict_cnt}, 32'd15);

        // Reset mid-read: grant in the reset cycle is discarded
        set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        set_m1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        reset = 1'b1;
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        check("rst_mid_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        check("rst_mid_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        check("rst_mid_cnt", {16'b0, conflict_cnt}, 32'd0);
        check("rst_mid_sat_cnt", {28'b0, s_conflict_cnt}, 32'd0);
        // rr_last back to 1: master 0 wins the next tie
        tick(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
        set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D);
        idle();
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);

        check("drain_exp_q", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
